mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, sitting between the EX/MEM pipeline register and the write-back stage. It consumes the EX/MEM register outputs and drives the data-memory port through a req/ack handshake with variable latency. It stalls the front of the pipeline while an access is outstanding, resolves the branch decision, and contains the MEM/WB pipeline register.

## Interface
Parameters:
- WAIT_LIMIT, 15: maximum wait cycles for dmem_ack before an access is aborted (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset; synchronous and active-high.
- PC_in  in  64  branch target from EX/MEM.
- aluResult_in  in  64  ALU result / memory address.
- data2_in  in  64  store data.
- rd_in  in  5  destination register.
- Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in, zero_in  in  1 each  EX/MEM control bits.
- PCSrc  out  1  branch taken (combinational).
- branch_target  out  64  equals PC_in (combinational).
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational).
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  64  memory address.
- dmem_wdata  out  64  store data.
- dmem_rdata  in  64  load data; valid when dmem_ack = 1.
- dmem_ack  in  1  access complete; one-cycle pulse.
- readData_out, aluResult_out  out  64 each  MEM/WB register.
- rd_out  out  5  MEM/WB register.
- MemtoReg_out, RegWrite_out, valid_out  out  1 each  MEM/WB register.
- mem_err  out  1  sticky timeout flag.

## Operation
- access = MemRead_in | MemWrite_in. If both are set, the access is a write (dmem_we = 1).
- FSM states: IDLE and WAIT.
- IDLE, access = 1: drive dmem_req = 1, dmem_addr = aluResult_in, dmem_wdata = data2_in, dmem_we = MemWrite_in.
  - If dmem_ack = 1 in the same cycle, complete with zero stall.
  - Otherwise latch addr, wdata, we, rd_in, MemtoReg_in, RegWrite_in, and aluResult_in, clear the wait counter, and go to WAIT.
- WAIT: hold dmem_req = 1 with the latched values; inputs are ignored. The wait counter increments each cycle.
  - On dmem_ack: complete and return to IDLE.
  - If the counter reaches WAIT_LIMIT without ack: abort, set mem_err, return to IDLE.
- Completion or non-access instruction in IDLE: MEM/WB loads readData (dmem_rdata on load completion, else 0), aluResult, rd, MemtoReg, RegWrite, and valid_out = 1.
- Completed write: RegWrite_out is the latched/incoming RegWrite (normally 0).
- Stall cycle or abort: MEM/WB loads a bubble (valid_out = 0, RegWrite_out = 0, MemtoReg_out = 0, rd_out = 0; data fields hold).
- stall = (IDLE & access & ~dmem_ack) | (WAIT & ~dmem_ack & ~timeout).
- PCSrc = Branch_in & zero_in & (state == IDLE).
- mem_err is cleared only by reset. Dropped loads are not retried.

## Timing
- Reset (synchronous): state IDLE, counter 0, all MEM/WB outputs 0, mem_err 0. dmem_req, PCSrc and stall follow their combinational equations in IDLE.
- Reset asserted in WAIT: dmem_req drops the next cycle and no MEM/WB update occurs.
- Latency: MEM/WB outputs are valid one cycle after the completing edge. A zero-wait access costs 0 stall cycles; an N-cycle ack costs N stall cycles.
- dmem_req is never deasserted before ack, timeout, or reset.
- dmem_addr, dmem_wdata and dmem_we are stable throughout WAIT.
- Ack in the same cycle the counter hits WAIT_LIMIT: completion wins and mem_err is not set.
- dmem_ack in IDLE with no access is ignored.

## Test plan
- Reset, then ALU op (aluResult_in = 0x10, rd_in = 5, RegWrite_in = 1): the next cycle gives aluResult_out = 0x10, rd_out = 5, RegWrite_out = 1, valid_out = 1, stall = 0, dmem_req = 0.
- Load with addr 0x100 and ack after 3 cycles with rdata 0xDEADBEEF: stall is high for exactly 3 cycles, MEM/WB carries bubbles meanwhile, then readData_out = 0xDEADBEEF and MemtoReg_out = 1.
- Store addr 0x200, data 0x55, zero-wait ack: dmem_we = 1, no stall, RegWrite_out = 0.
- Branch_in = 1, zero_in = 1, PC_in = 0x400: PCSrc = 1, branch_target = 0x400. With zero_in = 0: PCSrc = 0.
- Load with ack never asserted, WAIT_LIMIT = 15: abort after 15 wait cycles, mem_err = 1, stall drops, RegWrite_out = 0. mem_err stays 1 until reset.
- Reset asserted in the 2nd WAIT cycle: the next cycle has state IDLE, dmem_req = 0 (no access pending), all outputs 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// The request side is held stable until the access is acknowledged.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: variable-latency data-memory access with a wait timeout,
// front-end stall, branch resolution and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC_in,
  input  logic [63:0] aluResult_in,
  input  logic [63:0] data2_in,
  input  logic [4:0]  rd_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        zero_in,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic [63:0] readData_out,
  output logic [63:0] aluResult_out,
  output logic [4:0]  rd_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        valid_out,
  output logic        mem_err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT     = 1'b1;
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d;
  logic        we_q, we_d, m2r_q, m2r_d, rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d, wb_valid_q, wb_valid_d;
  logic        err_q, err_d;
  logic        access_s, timeout_s;

  assign access_s  = MemRead_in | MemWrite_in;
  // Counter holds the number of WAIT cycles already completed; abort at the edge closing the last allowed one.
  assign timeout_s = (state_q == WAIT) && (cnt_q == LIMIT_M1);

  // Memory port, stall and branch resolution
  always_comb begin
    if (state_q == WAIT) begin
      dmem.dmem_req   = 1'b1;
      dmem.dmem_we    = we_q;
      dmem.dmem_addr  = addr_q;
      dmem.dmem_wdata = wdata_q;
      stall           = ~dmem.dmem_ack & ~timeout_s;
    end else begin
      dmem.dmem_req   = access_s;
      dmem.dmem_we    = MemWrite_in;
      dmem.dmem_addr  = aluResult_in;
      dmem.dmem_wdata = data2_in;
      stall           = access_s & ~dmem.dmem_ack;
    end
    PCSrc         = Branch_in & zero_in & (state_q == IDLE);
    branch_target = PC_in;
  end

  // Next-state for the access FSM, latched request and MEM/WB register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    alu_d      = alu_q;
    we_d       = we_q;
    m2r_d      = m2r_q;
    rw_d       = rw_q;
    rd_d       = rd_q;
    err_d      = err_q;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_rd_d    = 5'd0;
    wb_m2r_d   = 1'b0;
    wb_rw_d    = 1'b0;
    wb_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s && !dmem.dmem_ack) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
          addr_d  = aluResult_in;
          wdata_d = data2_in;
          alu_d   = aluResult_in;
          we_d    = MemWrite_in;
          m2r_d   = MemtoReg_in;
          rw_d    = RegWrite_in;
          rd_d    = rd_in;
        end else begin
          wb_rdata_d = (access_s && !MemWrite_in) ? dmem.dmem_rdata : 64'd0;
          wb_alu_d   = aluResult_in;
          wb_rd_d    = rd_in;
          wb_m2r_d   = MemtoReg_in;
          wb_rw_d    = RegWrite_in;
          wb_valid_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Ack beats the timeout when both land in the same cycle.
        if (dmem.dmem_ack) begin
          state_d    = IDLE;
          wb_rdata_d = we_q ? 64'd0 : dmem.dmem_rdata;
          wb_alu_d   = alu_q;
          wb_rd_d    = rd_q;
          wb_m2r_d   = m2r_q;
          wb_rw_d    = rw_q;
          wb_valid_d = 1'b1;
        end else if (timeout_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline register update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      alu_q      <= 64'd0;
      we_q       <= 1'b0;
      m2r_q      <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      wb_rdata_q <= 64'd0;
      wb_alu_q   <= 64'd0;
      wb_rd_q    <= 5'd0;
      wb_m2r_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      alu_q      <= alu_d;
      we_q       <= we_d;
      m2r_q      <= m2r_d;
      rw_q       <= rw_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rw_q    <= wb_rw_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign readData_out  = wb_rdata_q;
  assign aluResult_out = wb_alu_q;
  assign rd_out        = wb_rd_q;
  assign MemtoReg_out  = wb_m2r_q;
  assign RegWrite_out  = wb_rw_q;
  assign valid_out     = wb_valid_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, waited load, zero-wait store,
// branch resolution, ack at the wait limit, timeout abort and reset during WAIT.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC_in, aluResult_in, data2_in;
  logic [4:0]  rd_in;
  logic        Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in, zero_in;
  logic        PCSrc, stall;
  logic [63:0] branch_target, readData_out, aluResult_out;
  logic [4:0]  rd_out;
  logic        MemtoReg_out, RegWrite_out, valid_out, mem_err;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  mem_stage_if bus ();

  mem_stage #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .aluResult_in(aluResult_in),
    .data2_in(data2_in), .rd_in(rd_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .zero_in(zero_in), .PCSrc(PCSrc),
    .branch_target(branch_target), .stall(stall), .dmem(bus),
    .readData_out(readData_out), .aluResult_out(aluResult_out), .rd_out(rd_out),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .valid_out(valid_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    PC_in = 64'd0; aluResult_in = 64'd0; data2_in = 64'd0; rd_in = 5'd0;
    Branch_in = 1'b0; MemRead_in = 1'b0; MemtoReg_in = 1'b0; MemWrite_in = 1'b0;
    RegWrite_in = 1'b0; zero_in = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    settle();
    check("rst_valid", valid_out, 1'b0);
    check("rst_rdata", readData_out, 64'd0);
    check("rst_err", mem_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_req", bus.dmem_req, 1'b0);

    // ALU op
    tick();
    reset = 1'b0;
    aluResult_in = 64'h10; rd_in = 5'd5; RegWrite_in = 1'b1;
    settle();
    check("alu_stall", stall, 1'b0);
    check("alu_req", bus.dmem_req, 1'b0);
    tick();
    idle_inputs();
    settle();
    check("alu_res", aluResult_out, 64'h10);
    check("alu_rd", rd_out, 5'd5);
    check("alu_rw", RegWrite_out, 1'b1);
    check("alu_valid", valid_out, 1'b1);

    // Load, ack after 3 stall cycles
    tick();
    MemRead_in = 1'b1; MemtoReg_in = 1'b1; RegWrite_in = 1'b1;
    aluResult_in = 64'h100; rd_in = 5'd7;
    settle();
    check("ld_req0", bus.dmem_req, 1'b1);
    check("ld_we0", bus.dmem_we, 1'b0);
    check("ld_addr0", bus.dmem_addr, 64'h100);
    check("ld_stall0", stall, 1'b1);
    tick();
    aluResult_in = 64'h999;
    settle();
    check("ld_addr1", bus.dmem_addr, 64'h100);
    check("ld_stall1", stall, 1'b1);
    check("ld_bub1", valid_out, 1'b0);
    check("ld_bubrw1", RegWrite_out, 1'b0);
    tick();
    settle();
    check("ld_stall2", stall, 1'b1);
    check("ld_bub2", valid_out, 1'b0);
    tick();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hDEADBEEF;
    settle();
    check("ld_stall3", stall, 1'b0);
    check("ld_req3", bus.dmem_req, 1'b1);
    tick();
    idle_inputs();
    settle();
    check("ld_rdata", readData_out, 64'hDEADBEEF);
    check("ld_m2r", MemtoReg_out, 1'b1);
    check("ld_rd", rd_out, 5'd7);
    check("ld_alu", aluResult_out, 64'h100);
    check("ld_valid", valid_out, 1'b1);
    check("ld_reqoff", bus.dmem_req, 1'b0);

    // Zero-wait store
    tick();
    MemWrite_in = 1'b1; aluResult_in = 64'h200; data2_in = 64'h55;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h77;
    settle();
    check("st_we", bus.dmem_we, 1'b1);
    check("st_addr", bus.dmem_addr, 64'h200);
    check("st_wdata", bus.dmem_wdata, 64'h55);
    check("st_stall", stall, 1'b0);
    tick();
    MemRead_in = 1'b1; MemWrite_in = 1'b1; aluResult_in = 64'h208;
    settle();
    check("st_rw", RegWrite_out, 1'b0);
    check("st_valid", valid_out, 1'b1);
    check("st_rdata", readData_out, 64'd0);
    check("rw_both_we", bus.dmem_we, 1'b1);
    tick();
    idle_inputs();

    // Branch resolution and stray ack
    Branch_in = 1'b1; zero_in = 1'b1; PC_in = 64'h400;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h1234;
    settle();
    check("br_taken", PCSrc, 1'b1);
    check("br_target", branch_target, 64'h400);
    check("stray_stall", stall, 1'b0);
    check("stray_req", bus.dmem_req, 1'b0);
    tick();
    zero_in = 1'b0;
    bus.dmem_ack = 1'b0;
    settle();
    check("br_nottaken", PCSrc, 1'b0);
    check("stray_rdata", readData_out, 64'd0);
    check("stray_valid", valid_out, 1'b1);

    // Ack in the same cycle the wait limit is reached
    tick();
    idle_inputs();
    MemRead_in = 1'b1; RegWrite_in = 1'b1; rd_in = 5'd3; aluResult_in = 64'h280;
    settle();
    check("lim_stall0", stall, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      settle();
      check("lim_stall", stall, 1'b1);
    end
    tick();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hABCD;
    settle();
    check("lim_stall15", stall, 1'b0);
    tick();
    idle_inputs();
    settle();
    check("lim_rdata", readData_out, 64'hABCD);
    check("lim_valid", valid_out, 1'b1);
    check("lim_err", mem_err, 1'b0);

    // Timeout abort
    tick();
    MemRead_in = 1'b1; MemtoReg_in = 1'b1; RegWrite_in = 1'b1;
    rd_in = 5'd9; aluResult_in = 64'h300;
    settle();
    check("to_stall0", stall, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      Branch_in = 1'b1; zero_in = 1'b1;
      settle();
      check("to_stall", stall, 1'b1);
      check("to_pcsrc_wait", PCSrc, 1'b0);
    end
    tick();
    settle();
    check("to_stall15", stall, 1'b0);
    check("to_req15", bus.dmem_req, 1'b1);
    check("to_err_pre", mem_err, 1'b0);
    tick();
    idle_inputs();
    settle();
    check("to_err", mem_err, 1'b1);
    check("to_rw", RegWrite_out, 1'b0);
    check("to_valid", valid_out, 1'b0);
    check("to_req_off", bus.dmem_req, 1'b0);
    check("to_stall_off", stall, 1'b0);
    tick();
    tick();
    settle();
    check("to_err_sticky", mem_err, 1'b1);
    check("to_valid_next", valid_out, 1'b1);

    // Reset asserted in the second WAIT cycle
    tick();
    MemRead_in = 1'b1; RegWrite_in = 1'b1; rd_in = 5'd4; aluResult_in = 64'h500;
    tick();
    tick();
    reset = 1'b1;
    idle_inputs();
    settle();
    check("rw_req_wait2", bus.dmem_req, 1'b1);
    tick();
    reset = 1'b0;
    settle();
    check("rw_req", bus.dmem_req, 1'b0);
    check("rw_stall", stall, 1'b0);
    check("rw_valid", valid_out, 1'b0);
    check("rw_alu", aluResult_out, 64'd0);
    check("rw_rd", rd_out, 5'd0);
    check("rw_err", mem_err, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
